radar_sweep_ctrl: RTL and testbench

Upstream sequencer for the radar servo PWM stage. Drives the 2-bit servo position code (1=0°, 2=90°, 3=180°) in a ping-pong sweep 1→2→3→2→1…. At each position it waits for the servo to settle, then requests one range measurement from the ultrasonic ranger over a req/done handshake. It then publishes the tagged distance and advances to the next position.

---
 rtl/radar_sweep_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_radar_sweep_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/radar_sweep_ctrl.sv
// Radar sweep sequencer: ping-pong servo steps, settle, range request, publish.
// Optional RADAR_MANUAL_EN adds debounced manual stepping (btn_step, manual).
module radar_sweep_ctrl #(
  parameter int DWELL_CYCLES   = 25_000_000,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int DIST_W         = 9
`ifdef RADAR_MANUAL_EN
  ,
  parameter int DEBOUNCE_CYCLES = 500_000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
`ifdef RADAR_MANUAL_EN
  input  logic              btn_step,
  input  logic              manual,
`endif
  output logic [1:0]        pos,
  output logic              meas_req,
  input  logic              meas_done,
  input  logic [DIST_W-1:0] meas_dist,
  output logic              dist_valid,
  output logic [DIST_W-1:0] dist_out,
  output logic [1:0]        dist_pos,
  output logic              timeout
);

  localparam int MAXC = (DWELL_CYCLES > TIMEOUT_CYCLES) ?
                        DWELL_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, REQ, WAIT, ADVANCE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              up, up_n;
  logic [1:0]        pos_n;
  logic              req_n, valid_n, to_n;
  logic [DIST_W-1:0] dout_n;
  logic [1:0]        dpos_n;
  logic              hold_idle;
  logic              step;

`ifdef RADAR_MANUAL_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]     sync;
  logic [DBW-1:0] db_cnt;
  logic           db_lvl;
  logic           press;

  // level must differ from the accepted level for the full window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      db_cnt <= '0;
      db_lvl <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_step};
      press <= 1'b0;
      if (sync[1] == db_lvl) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        db_lvl <= sync[1];
        press  <= sync[1];
      end else begin
        db_cnt <= db_cnt + DBW'(1);
      end
    end
  end

  assign hold_idle = manual;
  assign step      = press;
`else
  assign hold_idle = 1'b0;
  assign step      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      up         <= 1'b1;
      pos        <= 2'd1;
      meas_req   <= 1'b0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      dist_out   <= '0;
      dist_pos   <= 2'd0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      up         <= up_n;
      pos        <= pos_n;
      meas_req   <= req_n;
      dist_valid <= valid_n;
      timeout    <= to_n;
      dist_out   <= dout_n;
      dist_pos   <= dpos_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    up_n    = up;
    pos_n   = pos;
    req_n   = 1'b0;
    valid_n = 1'b0;
    to_n    = 1'b0;
    dout_n  = dist_out;
    dpos_n  = dist_pos;
    unique case (state)
      IDLE: begin
        if (hold_idle) begin
          if (step) state_n = ADVANCE;
        end else if (enable) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end
      end
      SETTLE: begin
        if (cnt == DWELL_LAST) begin
          state_n = REQ;
          req_n   = 1'b1;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      REQ: begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT: begin
        // a done on the terminal count still beats the timeout
        if (meas_done) begin
          dout_n  = meas_dist;
          dpos_n  = pos;
          valid_n = 1'b1;
          state_n = ADVANCE;
        end else if (cnt == TO_LAST) begin
          dout_n  = '1;
          dpos_n  = pos;
          valid_n = 1'b1;
          to_n    = 1'b1;
          state_n = ADVANCE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ADVANCE: begin
        if (up) begin
          if (pos == 2'd3) begin
            pos_n = 2'd2;
            up_n  = 1'b0;
          end else begin
            pos_n = pos + 2'd1;
          end
        end else begin
          if (pos == 2'd1) begin
            pos_n = 2'd2;
            up_n  = 1'b1;
          end else begin
            pos_n = pos - 2'd1;
          end
        end
        if (enable && !hold_idle) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Bench for radar_sweep_ctrl: vector table plus random ranger latencies,
// checked against a step-count sweep model and cycle-timing rules.
module tb_radar_sweep_ctrl;
  localparam int D = 10;
  localparam int T = 20;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         meas_done;
  logic [W-1:0] meas_dist;
  logic [1:0]   pos;
  logic         meas_req;
  logic         dist_valid;
  logic [W-1:0] dist_out;
  logic [1:0]   dist_pos;
  logic         timeout;
`ifdef RADAR_MANUAL_EN
  logic         btn_step = 1'b0;
  logic         manual = 1'b0;
`endif

  radar_sweep_ctrl #(
    .DWELL_CYCLES(D), .TIMEOUT_CYCLES(T), .DIST_W(W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef RADAR_MANUAL_EN
    .btn_step(btn_step), .manual(manual),
`endif
    .pos(pos), .meas_req(meas_req),
    .meas_done(meas_done), .meas_dist(meas_dist),
    .dist_valid(dist_valid), .dist_out(dist_out),
    .dist_pos(dist_pos), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int exp_req = -1;

  typedef struct {
    int           lat;
    logic [W-1:0] val;
    bit           stray;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // sweep is the repeating pattern 1,2,3,2 indexed by completed steps
  function automatic logic [1:0] model_pos(input int n);
    case (n % 4)
      0: return 2'd1;
      1: return 2'd2;
      2: return 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_pos"}, pos, 1);
    check({tag, "_req"}, meas_req, 0);
    check({tag, "_valid"}, dist_valid, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_dist"}, dist_out, 0);
    check({tag, "_dpos"}, dist_pos, 0);
  endtask

  task automatic start_sweep();
    enable  = 1'b1;
    exp_req = cyc + 1 + D;
  endtask

  task automatic quiet(input string tag, input int ncyc);
    bit saw_req;
    bit saw_valid;
    saw_req   = 0;
    saw_valid = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      meas_done = 1'b0;
      if (meas_req) saw_req = 1;
      if (dist_valid) saw_valid = 1;
    end
    check({tag, "_noreq"}, saw_req, 0);
    check({tag, "_novalid"}, saw_valid, 0);
  endtask

  // lat: cycles after the req cycle at which done is driven; 0 = never
  task automatic run_one(input int lat, input logic [W-1:0] val,
                         input bit stray);
    int n;
    int r;
    int eff;
    bit got;
    logic [W-1:0] exp_d;
    got = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (meas_req) begin
        got = 1;
        break;
      end
    end
    check("req_seen", got, 1);
    if (!got) return;
    r = cyc;
    if (exp_req >= 0) check("req_time", r, exp_req);
    check("req_pos", pos, model_pos(k));
    meas_done = stray;
    meas_dist = 9'h0AA;
    eff = (lat == 0) ? T : lat;
    got = 0;
    for (n = 1; n < T + 10; n++) begin
      @(negedge clk);
      if (n == 1) check("req_pulse", meas_req, 0);
      if (dist_valid) begin
        got = 1;
        break;
      end
      meas_done = (lat != 0) && (n == lat);
      meas_dist = val;
    end
    meas_done = 1'b0;
    check("valid_seen", got, 1);
    if (!got) return;
    exp_d = (lat == 0) ? 9'h1FF : val;
    check("valid_lat", n, eff + 1);
    check("dist_out", dist_out, exp_d);
    check("dist_pos", dist_pos, model_pos(k));
    check("timeout", timeout, (lat == 0));
    exp_req = cyc + 1 + D;
    k++;
    @(negedge clk);
    check("valid_pulse", dist_valid, 0);
    check("timeout_pulse", timeout, 0);
  endtask

  initial begin
    bit got;
    rst       = 1'b1;
    enable    = 1'b0;
    meas_done = 1'b0;
    meas_dist = '0;

    for (int i = 0; i < 6; i++)
      tbl[i] = '{lat: 4, val: W'(100 + i), stray: 1'b0};
    tbl[6] = '{lat: 0, val: '0, stray: 1'b0};
    tbl[7] = '{lat: T, val: W'(55), stray: 1'b0};
    for (int i = 8; i < 17; i++) begin
      tbl[i].lat   = $urandom_range(0, T);
      tbl[i].val   = W'($urandom);
      tbl[i].stray = 1'($urandom_range(0, 1));
    end

    repeat (2) @(negedge clk);
    check_reset("rst");
    rst = 1'b0;
    quiet("idle", 3 * D);
    check("idle_pos", pos, 1);

    start_sweep();
    for (int i = 0; i < 17; i++)
      run_one(tbl[i].lat, tbl[i].val, tbl[i].stray);

    // pos=2 going up, now in SETTLE: drop enable
    enable = 1'b0;
    run_one(4, 9'd200, 1'b0);
    quiet("paused", 4 * D);
    check("paused_pos", pos, model_pos(k));
    start_sweep();
    run_one(4, 9'd201, 1'b0);
    run_one(4, 9'd202, 1'b0);

    got = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (meas_req) begin
        got = 1;
        break;
      end
    end
    check("pre_rst_req", got, 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset("async_rst");
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    meas_done = 1'b1;
    meas_dist = 9'd77;
    quiet("stray", 2 * D);
    k = 0;
    start_sweep();
    run_one(4, 9'd300, 1'b0);
    run_one(0, 9'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
